// File: rtl/amiga_kbd_txqueue.sv
// Amiga keyboard keycode queue and handshake sequencer feeding the serial transmitter.
// Optional power-up FD/FE codes: define AMIGA_KBD_POWERUP_EN.
module amiga_kbd_txqueue #(
    parameter int DEPTH_LOG2    = 3,
    parameter int TIMEOUT_TICKS = 1014000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk7_en,
    input  logic                  in_strobe,
    input  logic [7:0]            in_data,
    input  logic                  keyack,
    output logic                  key_strobe,
    output logic [7:0]            key_data,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_TICKS - 1);

`ifdef AMIGA_KBD_POWERUP_EN
    localparam logic PWR_ARM = 1'b1;
`else
    localparam logic PWR_ARM = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_ACK} state_t;
    state_t state_reg, state_next;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_reg, rd_ptr_reg;
    logic                fifo_empty, fifo_full;
    logic                pop, push_ok;

    logic       pwr_fd_reg, pwr_fd_next;
    logic       pwr_fe_reg, pwr_fe_next;
    logic       sync_pend_reg, sync_pend_next;
    logic       ovf_pend_reg, ovf_pend_next;
    logic       resend_reg, resend_next;
    logic       sending_sync_reg, sending_sync_next;
    logic [7:0] cur_code_reg, cur_code_next;
    logic [7:0] resend_code_reg, resend_code_next;
    logic [19:0] tmo_cnt_reg, tmo_cnt_next;
    logic       key_strobe_reg, key_strobe_next;
    logic [7:0] key_data_reg, key_data_next;

    assign fifo_level = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == (DEPTH_LOG2 + 1)'(DEPTH));
    // A pop frees a slot in the same cycle, so a push into a full FIFO still fits.
    assign push_ok    = in_strobe && (!fifo_full || pop);

    assign key_strobe = key_strobe_reg;
    assign key_data   = key_data_reg;
    assign busy       = (state_reg != ST_IDLE);

    always_comb begin
        state_next        = state_reg;
        pwr_fd_next       = pwr_fd_reg;
        pwr_fe_next       = pwr_fe_reg;
        sync_pend_next    = sync_pend_reg;
        ovf_pend_next     = ovf_pend_reg;
        resend_next       = resend_reg;
        sending_sync_next = sending_sync_reg;
        cur_code_next     = cur_code_reg;
        resend_code_next  = resend_code_reg;
        tmo_cnt_next      = tmo_cnt_reg;
        key_strobe_next   = key_strobe_reg;
        key_data_next     = key_data_reg;
        pop               = 1'b0;

        if (clk7_en) begin
            key_strobe_next = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    sending_sync_next = 1'b0;
                    if (pwr_fd_reg) begin
                        cur_code_next = 8'hFD;
                        pwr_fd_next   = 1'b0;
                        state_next    = ST_SEND;
                    end else if (pwr_fe_reg) begin
                        cur_code_next = 8'hFE;
                        pwr_fe_next   = 1'b0;
                        state_next    = ST_SEND;
                    end else if (sync_pend_reg) begin
                        cur_code_next     = 8'hF9;
                        sync_pend_next    = 1'b0;
                        sending_sync_next = 1'b1;
                        state_next        = ST_SEND;
                    end else if (resend_reg) begin
                        cur_code_next = resend_code_reg;
                        resend_next   = 1'b0;
                        state_next    = ST_SEND;
                    end else if (ovf_pend_reg) begin
                        cur_code_next = 8'hFA;
                        ovf_pend_next = 1'b0;
                        state_next    = ST_SEND;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_SEND;
                    end
                end
                ST_SEND: begin
                    key_strobe_next = 1'b1;
                    key_data_next   = cur_code_reg;
                    tmo_cnt_next    = '0;
                    state_next      = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (keyack) begin
                        state_next = ST_IDLE;
                    end else if (tmo_cnt_reg >= TIMEOUT_LAST) begin
                        sync_pend_next = 1'b1;
                        resend_next    = 1'b1;
                        // A timed-out F9 must not replace the code waiting to be resent.
                        if (!sending_sync_reg)
                            resend_code_next = cur_code_reg;
                        state_next = ST_IDLE;
                    end else if (tmo_cnt_reg != '1) begin
                        tmo_cnt_next = tmo_cnt_reg + 20'd1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        if (in_strobe && fifo_full && !pop)
            ovf_pend_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            pwr_fd_reg       <= PWR_ARM;
            pwr_fe_reg       <= PWR_ARM;
            sync_pend_reg    <= 1'b0;
            ovf_pend_reg     <= 1'b0;
            resend_reg       <= 1'b0;
            sending_sync_reg <= 1'b0;
            resend_code_reg  <= 8'h00;
            tmo_cnt_reg      <= '0;
            key_strobe_reg   <= 1'b0;
            key_data_reg     <= 8'h00;
        end else begin
            state_reg        <= state_next;
            if (push_ok)
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            pwr_fd_reg       <= pwr_fd_next;
            pwr_fe_reg       <= pwr_fe_next;
            sync_pend_reg    <= sync_pend_next;
            ovf_pend_reg     <= ovf_pend_next;
            resend_reg       <= resend_next;
            sending_sync_reg <= sending_sync_next;
            resend_code_reg  <= resend_code_next;
            tmo_cnt_reg      <= tmo_cnt_next;
            key_strobe_reg   <= key_strobe_next;
            key_data_reg     <= key_data_next;
        end
    end

    // FIFO head is read straight into cur_code, keeping the RAM read registered.
    always_ff @(posedge clk) begin
        if (reset)
            cur_code_reg <= 8'h00;
        else if (pop)
            cur_code_reg <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
        else
            cur_code_reg <= cur_code_next;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= in_data;
    end

endmodule
